// File: rtl/wb_burst_master_if.sv
// Wishbone initiator-side bus bundle for the burst master.
// The master modport drives the cycle; the slave modport answers it.
interface wb_burst_master_if #(
  parameter int APP_AW = 26,
  parameter int dw     = 32
);
  logic              wb_cyc_o;
  logic              wb_stb_o;
  logic              wb_we_o;
  logic [APP_AW-1:0] wb_addr_o;
  logic [dw-1:0]     wb_dat_o;
  logic [dw/8-1:0]   wb_sel_o;
  logic [2:0]        wb_cti_o;
  logic [dw-1:0]     wb_dat_i;
  logic              wb_ack_i;

  modport master (
    output wb_cyc_o, wb_stb_o, wb_we_o, wb_addr_o, wb_dat_o, wb_sel_o, wb_cti_o,
    input  wb_dat_i, wb_ack_i
  );

  modport slave (
    input  wb_cyc_o, wb_stb_o, wb_we_o, wb_addr_o, wb_dat_o, wb_sel_o, wb_cti_o,
    output wb_dat_i, wb_ack_i
  );
endinterface

// File: rtl/wb_burst_master.sv
// Wishbone incrementing-burst initiator: one command becomes one WB cycle,
// with write beats streamed in and read beats streamed out, guarded by an ack watchdog.
module wb_burst_master #(
  parameter int APP_AW  = 26,
  parameter int dw      = 32,
  parameter int bl      = 9,
  parameter int TIMEOUT = 255
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_we,
  input  logic [APP_AW-1:0] cmd_addr,
  input  logic [bl-1:0]     cmd_len,
  input  logic [dw-1:0]     wr_data,
  input  logic [dw/8-1:0]   wr_sel,
  input  logic              wr_valid,
  output logic              wr_ready,
  output logic [dw-1:0]     rd_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic              done,
  output logic              err,
  wb_burst_master_if.master wb
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] WR_WAIT = 3'd1;
  localparam logic [2:0] WR_BUS  = 3'd2;
  localparam logic [2:0] RD_BUS  = 3'd3;
  localparam logic [2:0] RD_HOLD = 3'd4;
  localparam logic [2:0] FIN     = 3'd5;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_END     = 3'b111;

  localparam int                WDW     = $clog2(TIMEOUT + 1);
  localparam logic [WDW-1:0]    WD_LAST = WDW'(TIMEOUT - 1);
  localparam logic [APP_AW-1:0] STEP    = APP_AW'(dw / 8);
  localparam logic [bl-1:0]     ONE     = bl'(1);

  logic [2:0]        state;
  logic [APP_AW-1:0] addr_q;
  logic [bl-1:0]     cnt;
  logic              single_q;
  logic [dw-1:0]     dat_q;
  logic [dw/8-1:0]   sel_q;
  logic [WDW-1:0]    wdog;
  logic              err_q;

  logic stb;
  logic ack_hit;
  logic wd_expire;

  assign stb       = (state == WR_BUS) || (state == RD_BUS);
  assign ack_hit   = stb && wb.wb_ack_i;
  assign wd_expire = stb && !wb.wb_ack_i && (wdog == WD_LAST);

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state    <= IDLE;
      addr_q   <= '0;
      cnt      <= '0;
      single_q <= 1'b0;
      dat_q    <= '0;
      sel_q    <= '0;
      wdog     <= '0;
      err_q    <= 1'b0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      // Watchdog only advances while a strobe is outstanding; each ack restarts it.
      if (stb) wdog <= ack_hit ? '0 : wdog + WDW'(1);

      case (state)
        IDLE: begin
          if (cmd_valid) begin
            addr_q   <= cmd_addr;
            cnt      <= cmd_len;
            single_q <= (cmd_len == ONE);
            err_q    <= 1'b0;
            wdog     <= '0;
            if (cmd_len == '0) state <= FIN;
            else               state <= cmd_we ? WR_WAIT : RD_BUS;
          end
        end
        WR_WAIT: begin
          if (wr_valid) begin
            dat_q <= wr_data;
            sel_q <= wr_sel;
            state <= WR_BUS;
          end
        end
        WR_BUS: begin
          if (ack_hit) begin
            cnt    <= cnt - ONE;
            addr_q <= addr_q + STEP;
            state  <= (cnt == ONE) ? FIN : WR_WAIT;
          end else if (wd_expire) begin
            err_q <= 1'b1;
            state <= FIN;
          end
        end
        RD_BUS: begin
          if (ack_hit) begin
            rd_data  <= wb.wb_dat_i;
            rd_valid <= 1'b1;
            cnt      <= cnt - ONE;
            addr_q   <= addr_q + STEP;
            state    <= RD_HOLD;
          end else if (wd_expire) begin
            rd_valid <= 1'b0;
            err_q    <= 1'b1;
            state    <= FIN;
          end
        end
        RD_HOLD: begin
          // cnt was already decremented on the ack, so zero here means that was the last beat.
          if (rd_ready) begin
            rd_valid <= 1'b0;
            state    <= (cnt == '0) ? FIN : RD_BUS;
          end
        end
        FIN:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign cmd_ready = (state == IDLE);
  assign wr_ready  = (state == WR_WAIT);
  assign done      = (state == FIN);
  assign err       = (state == FIN) && err_q;

  assign wb.wb_cyc_o  = (state == WR_WAIT) || (state == WR_BUS) ||
                        (state == RD_BUS)  || (state == RD_HOLD);
  assign wb.wb_stb_o  = stb;
  assign wb.wb_we_o   = (state == WR_BUS);
  assign wb.wb_addr_o = addr_q;
  assign wb.wb_dat_o  = dat_q;
  assign wb.wb_sel_o  = (state == RD_BUS) ? '1 : sel_q;
  // cti derives from registered counters only, so it holds steady while a beat waits for ack.
  assign wb.wb_cti_o  = !stb     ? CTI_CLASSIC :
                        single_q ? CTI_CLASSIC :
                        (cnt == ONE) ? CTI_END : CTI_INCR;

endmodule

// File: tb/tb_wb_burst_master.sv
// Directed bench for wb_burst_master: bursts, back-pressure, single/empty commands,
// watchdog abort, mid-burst reset and address wrap.
module tb_wb_burst_master;
  localparam int APP_AW = 26;
  localparam int dw     = 32;
  localparam int bl     = 9;

  logic              clk = 1'b0;
  logic              rst;
  logic              cmd_valid, cmd_ready, cmd_we;
  logic [APP_AW-1:0] cmd_addr;
  logic [bl-1:0]     cmd_len;
  logic [dw-1:0]     wr_data;
  logic [dw/8-1:0]   wr_sel;
  logic              wr_valid, wr_ready;
  logic [dw-1:0]     rd_data;
  logic              rd_valid, rd_ready, done, err;

  int passes = 0;
  int total  = 0;

  wb_burst_master_if #(.APP_AW(APP_AW), .dw(dw)) bus ();

  wb_burst_master #(.APP_AW(APP_AW), .dw(dw), .bl(bl), .TIMEOUT(255)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_we   (cmd_we),
    .cmd_addr (cmd_addr),
    .cmd_len  (cmd_len),
    .wr_data  (wr_data),
    .wr_sel   (wr_sel),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .rd_ready (rd_ready),
    .done     (done),
    .err      (err),
    .wb       (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1, "bench did not finish");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic send_cmd(input logic we, input logic [APP_AW-1:0] a, input logic [bl-1:0] len);
    cmd_valid = 1'b1; cmd_we = we; cmd_addr = a; cmd_len = len;
    chk("cmd_ready", cmd_ready, 1);
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_stb(input string tag);
    int n = 0;
    while (!bus.wb_stb_o && n < 20) begin tick(); n++; end
    chk({tag, "_stb_up"}, bus.wb_stb_o, 1);
  endtask

  task automatic wait_wr_ready(input string tag);
    int n = 0;
    while (!wr_ready && n < 20) begin tick(); n++; end
    chk({tag, "_wr_ready"}, wr_ready, 1);
  endtask

  // Write beat; slave acks one cycle after stb rises.
  task automatic wr_beat(input string tag, input logic [31:0] d, input logic [3:0] s,
                         input logic [APP_AW-1:0] ea, input logic [2:0] ecti, input bit last);
    wait_wr_ready(tag);
    wr_valid = 1'b1; wr_data = d; wr_sel = s;
    tick();
    wr_valid = 1'b0; wr_data = ~d;
    chk({tag, "_stb"},  bus.wb_stb_o, 1);
    chk({tag, "_cyc"},  bus.wb_cyc_o, 1);
    chk({tag, "_we"},   bus.wb_we_o, 1);
    chk({tag, "_addr"}, bus.wb_addr_o, ea);
    chk({tag, "_cti"},  bus.wb_cti_o, ecti);
    chk({tag, "_dat"},  bus.wb_dat_o, d);
    chk({tag, "_sel"},  bus.wb_sel_o, s);
    tick();
    chk({tag, "_addr_hold"}, bus.wb_addr_o, ea);
    chk({tag, "_cti_hold"},  bus.wb_cti_o, ecti);
    bus.wb_ack_i = 1'b1;
    tick();
    bus.wb_ack_i = 1'b0;
    if (last) begin
      chk({tag, "_done"}, done, 1);
      chk({tag, "_err"},  err, 0);
      chk({tag, "_cyc_end"}, bus.wb_cyc_o, 0);
    end else begin
      chk({tag, "_cyc_between"}, bus.wb_cyc_o, 1);
      chk({tag, "_stb_between"}, bus.wb_stb_o, 0);
    end
  endtask

  task automatic rd_beat(input string tag, input logic [APP_AW-1:0] ea, input logic [2:0] ecti,
                         input logic [31:0] d, input int hold, input bit last);
    wait_stb(tag);
    chk({tag, "_addr"}, bus.wb_addr_o, ea);
    chk({tag, "_cti"},  bus.wb_cti_o, ecti);
    chk({tag, "_we"},   bus.wb_we_o, 0);
    chk({tag, "_sel"},  bus.wb_sel_o, 4'hF);
    tick();
    bus.wb_dat_i = d; bus.wb_ack_i = 1'b1;
    tick();
    bus.wb_ack_i = 1'b0; bus.wb_dat_i = ~d;
    chk({tag, "_rd_valid"}, rd_valid, 1);
    chk({tag, "_rd_data"},  rd_data, d);
    chk({tag, "_stb_hold"}, bus.wb_stb_o, 0);
    for (int h = 0; h < hold; h++) begin
      if (h == 0) bus.wb_ack_i = 1'b1;  // stray ack while stb is low must be ignored
      tick();
      bus.wb_ack_i = 1'b0;
      chk({tag, "_held_stb"},   bus.wb_stb_o, 0);
      chk({tag, "_held_cyc"},   bus.wb_cyc_o, 1);
      chk({tag, "_held_valid"}, rd_valid, 1);
      chk({tag, "_held_data"},  rd_data, d);
    end
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
    chk({tag, "_rd_valid_clr"}, rd_valid, 0);
    if (last) begin
      chk({tag, "_done"}, done, 1);
      chk({tag, "_err"},  err, 0);
      chk({tag, "_cyc_end"}, bus.wb_cyc_o, 0);
    end
  endtask

  initial begin
    int n;
    bit seen;
    rst = 1'b1; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = '0; cmd_len = '0;
    wr_data = '0; wr_sel = '0; wr_valid = 1'b0; rd_ready = 1'b0;
    bus.wb_dat_i = '0; bus.wb_ack_i = 1'b0;
    repeat (3) tick();
    rst = 1'b0;

    // Reset state
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_cyc",  bus.wb_cyc_o, 0);
    chk("rst_stb",  bus.wb_stb_o, 0);
    chk("rst_we",   bus.wb_we_o, 0);
    chk("rst_addr", bus.wb_addr_o, 0);
    chk("rst_cti",  bus.wb_cti_o, 0);
    chk("rst_sel",  bus.wb_sel_o, 0);
    chk("rst_done", done, 0);
    chk("rst_err",  err, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_wr_ready", wr_ready, 0);

    // T1: 4-beat write burst
    send_cmd(1'b1, 26'h100, 9'd4);
    chk("t1_cyc_wait", bus.wb_cyc_o, 1);
    chk("t1_stb_wait", bus.wb_stb_o, 0);
    wr_beat("t1_b0", 32'hA0A0_0001, 4'hF, 26'h100, 3'b010, 0);
    wr_beat("t1_b1", 32'hA0A0_0002, 4'h3, 26'h104, 3'b010, 0);
    wr_beat("t1_b2", 32'hA0A0_0003, 4'hC, 26'h108, 3'b010, 0);
    wr_beat("t1_b3", 32'hA0A0_0004, 4'h1, 26'h10C, 3'b111, 1);
    tick();
    chk("t1_done_pulse", done, 0);
    chk("t1_idle", cmd_ready, 1);

    // T2: 3-beat read, consumer stalls 5 cycles after beat 1
    send_cmd(1'b0, 26'h200, 9'd3);
    rd_beat("t2_b0", 26'h200, 3'b010, 32'h1111_2222, 5, 0);
    rd_beat("t2_b1", 26'h204, 3'b010, 32'h3333_4444, 0, 0);
    rd_beat("t2_b2", 26'h208, 3'b111, 32'h5555_6666, 1, 1);
    tick();

    // T3: single-beat write, then empty command
    send_cmd(1'b1, 26'h40, 9'd1);
    wr_beat("t3_single", 32'hDEAD_BEEF, 4'hF, 26'h40, 3'b000, 1);
    tick();
    send_cmd(1'b1, 26'h80, 9'd0);
    chk("t3_len0_done", done, 1);
    chk("t3_len0_err",  err, 0);
    chk("t3_len0_cyc",  bus.wb_cyc_o, 0);
    tick();
    chk("t3_len0_idle", cmd_ready, 1);
    chk("t3_len0_cyc2", bus.wb_cyc_o, 0);

    // T4: read with no ack -> watchdog abort after 255 strobe cycles
    send_cmd(1'b0, 26'h300, 9'd2);
    n = 0;
    while (bus.wb_stb_o && n < 400) begin tick(); n++; end
    chk("t4_stb_cycles", n, 255);
    chk("t4_done", done, 1);
    chk("t4_err",  err, 1);
    chk("t4_cyc",  bus.wb_cyc_o, 0);
    chk("t4_rd_valid", rd_valid, 0);
    tick();
    chk("t4_err_clear", err, 0);
    chk("t4_idle", cmd_ready, 1);

    // T5: reset during beat 2 of an 8-beat write
    send_cmd(1'b1, 26'h500, 9'd8);
    wr_beat("t5_b0", 32'h0000_0500, 4'hF, 26'h500, 3'b010, 0);
    wait_wr_ready("t5_b1");
    wr_valid = 1'b1; wr_data = 32'h0000_0504; wr_sel = 4'hF;
    tick();
    wr_valid = 1'b0;
    chk("t5_b1_stb",  bus.wb_stb_o, 1);
    chk("t5_b1_addr", bus.wb_addr_o, 26'h504);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_cyc",  bus.wb_cyc_o, 0);
    chk("t5_stb",  bus.wb_stb_o, 0);
    chk("t5_cmd_ready", cmd_ready, 1);
    seen = done;
    for (int i = 0; i < 4; i++) begin tick(); seen |= done; end
    chk("t5_no_done", seen, 0);

    // T6: address wrap at top of space
    send_cmd(1'b1, 26'h3FFFFFC, 9'd2);
    wr_beat("t6_b0", 32'hCAFE_0000, 4'hF, 26'h3FFFFFC, 3'b010, 0);
    wr_beat("t6_b1", 32'hCAFE_0001, 4'hF, 26'h0000000, 3'b111, 1);
    tick();

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
